pkt_push_arbiter: RTL

PKT_PUSH_ARBITER -- requirements
Module: pkt_push_arbiter

---
 rtl/pkt_push_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/pkt_push_arbiter.sv
// pkt_push_arbiter: round-robin packet-atomic arbiter pushing beats into a packet queue with length-cap abort.
module pkt_push_arbiter #(
    parameter int D_WIDTH   = 6,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*D_WIDTH-1:0]    s_data,
    input  logic [NUM_REQ-1:0]            s_valid,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [D_WIDTH-1:0]            m_data,
    output logic                          m_push,
    input  logic                          m_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   commit_cnt,
    output logic [15:0]                   drop_cnt
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BEATS);
    typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_t;
    state_t state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_q, last_d, rr_pick;
    logic [GW:0] sum, idx;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0] commit_q, commit_d, drop_q, drop_d;
    logic [D_WIDTH-1:0] sel;
    logic sel_valid, at_cap;
    // Walk farthest-to-nearest so the first valid requester after last_grant wins.
    always_comb begin
        rr_pick = last_q;
        sum = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_q} + (GW+1)'(k);
            idx = sum >= (GW+1)'(NUM_REQ) ? sum - (GW+1)'(NUM_REQ) : sum;
            if (s_valid[idx[GW-1:0]]) rr_pick = idx[GW-1:0];
        end
    end
    assign sel       = s_data[grant_q*D_WIDTH +: D_WIDTH];
    assign sel_valid = s_valid[grant_q];
    assign at_cap    = beat_q == BW'(MAX_BEATS-1) && !sel[D_WIDTH-2];
    assign m_data    = state_q == PASS && at_cap ? {2'b11, sel[D_WIDTH-3:0]} : sel;
    assign m_push    = !rst && state_q == PASS && sel_valid && m_ready;
    assign s_ready   = rst ? '0 : state_q == PASS ? NUM_REQ'(m_ready) << grant_q :
                       state_q == DISCARD ? NUM_REQ'(1) << grant_q : '0;
    assign grant_id   = grant_q;
    assign busy       = state_q != IDLE;
    assign commit_cnt = commit_q;
    assign drop_cnt   = drop_q;
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        beat_d   = beat_q;
        commit_d = commit_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: if (|s_valid) begin
                grant_d = rr_pick;
                beat_d  = '0;
                state_d = PASS;
            end
            PASS: if (m_push) begin
                beat_d = beat_q + 1'b1;
                if (sel[D_WIDTH-2]) begin
                    commit_d = !sel[D_WIDTH-1] ? commit_q + {15'd0, commit_q != 16'hFFFF} : commit_q;
                    drop_d   = sel[D_WIDTH-1] ? drop_q + {15'd0, drop_q != 16'hFFFF} : drop_q;
                    last_d   = grant_q;
                    state_d  = IDLE;
                end else if (at_cap) begin
                    drop_d  = drop_q + {15'd0, drop_q != 16'hFFFF};
                    state_d = DISCARD;
                end
            end
            default: if (sel_valid && sel[D_WIDTH-2]) begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NUM_REQ-1);
            beat_q   <= '0;
            commit_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
        end
    end
endmodule
